reg_bank: RTL and testbench
===========================

# reg_bank

General-purpose register file of the multicycle MIPS datapath: 32 registers of 32 bits, two combinational read ports, one synchronous write port. Sits directly downstream of the write-register select mux. It consumes the 5-bit destination index from that mux (rd, rt, 31 or 29) together with the ALU/memory write-back data. Read ports feed the A/B operand registers.

## Interface

Parameters:
- DATA_W, 32, register width
- SP_IDX, 29, index of the stack pointer register
- SP_RESET, 227, reset value of the stack pointer register

Ports:
- clk, input, 1, system clock; all state updates on rising edge
- reset, input, 1, synchronous, active-high; sampled on rising edge of clk
- RegWrite, input, 1, write enable from control unit
- ReadReg1, input, 5, read port 1 index (instruction rs)
- ReadReg2, input, 5, read port 2 index (instruction rt)
- WriteReg, input, 5, destination index from write-register select mux
- WriteData, input, DATA_W, write-back data
- ReadData1, output, DATA_W, contents of register ReadReg1
- ReadData2, output, DATA_W, contents of register ReadReg2

## Operation

- Storage is 32 × DATA_W flip-flop registers, indexed 0..31.
- Reset is synchronous, active-high, and has priority over everything else.
  - At a rising edge with reset=1, every register loads 0, except register SP_IDX, which loads SP_RESET.
  - RegWrite is ignored in that cycle.
- Write: at a rising edge with reset=0 and RegWrite=1, register[WriteReg] loads WriteData.
  - Only one register changes per cycle.
- Register 0 is hard-wired to zero.
  - A write to index 0 is discarded.
  - Reads of index 0 return 0 regardless of history.
- Register 31 ($ra) and register 29 ($sp) have no special write behaviour. They are ordinary writable registers; only their reset value differs for SP_IDX.
- Reads are combinational:
  - ReadData1 = register[ReadReg1]
  - ReadData2 = register[ReadReg2]
  - Both ports may address the same register, and both return the same value.
- No write-through bypass. If ReadReg equals WriteReg in the cycle of a write, the read returns the old value until after the edge. The multicycle control sequence never needs same-cycle forwarding.
- All bits of every index are used. There is no out-of-range index, since 5 bits address exactly 32 registers.

## Timing

- Reset values observed combinationally on the read ports after the reset edge:
  - ReadData of any index = 0
  - ReadData of SP_IDX = SP_RESET (227 decimal = 32'h000000E3)
- Write latency: 1 edge. The value is visible on the read ports immediately after the writing edge.
- Read latency: 0 cycles (combinational from ReadReg and register state).
- Write with RegWrite=0: no state change, even if WriteReg and WriteData toggle.
- Reset asserted in the same cycle as a write: reset wins, and the written value is lost.
- Reset deasserted: normal writes resume on the next edge.
- Consecutive writes to the same index on back-to-back edges: the last value wins.
- X/undefined inputs on WriteReg or WriteData while RegWrite=0 must not corrupt state.

## Structure

- Shared package (datapath constants) holds:
  - REG_ZERO = 5'd0
  - REG_SP = 5'd29
  - REG_RA = 5'd31
  - SP_RESET_VAL = 32'd227
  - These same constants are used by the write-register select mux and the control unit.
- Single module; no sub-module needed. Storage is a 32-entry array with a per-entry reset/write process and two read muxes.

## Test plan

- Reset: assert reset for 1 edge, then sweep ReadReg1 over 0..31 → 0 everywhere except index 29 = 227.
- Basic write/read: RegWrite=1, WriteReg=8, WriteData=32'hDEADBEEF, one edge, then ReadReg1=8 and ReadReg2=8 → both 32'hDEADBEEF; a write to index 9 afterward leaves index 8 unchanged.
- $zero protection: RegWrite=1, WriteReg=0, WriteData=32'hFFFFFFFF, one edge → ReadData1 at index 0 reads 0.
- Write disabled: RegWrite=0, WriteReg=5, WriteData=32'h12345678 → index 5 still holds its previous value (0 after reset).
- Same-cycle read/write: ReadReg1=31 and WriteReg=31 with WriteData=32'h00400010, RegWrite=1 → ReadData1 shows the old value before the edge and 32'h00400010 after it. Writing index 29 with 32'h100 → reads 32'h100, confirming $sp is writable.
- Reset during write: reset=1 and RegWrite=1 with WriteReg=29 and WriteData=32'h55 on the same edge → index 29 reads 227 and all others read 0.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Datapath constants shared by the register file, the write-register select mux
// and the control unit.
package reg_bank_pkg;

    localparam int          NUM_REGS     = 32;
    localparam int          IDX_W        = 5;

    localparam logic [4:0]  REG_ZERO     = 5'd0;
    localparam logic [4:0]  REG_SP       = 5'd29;
    localparam logic [4:0]  REG_RA       = 5'd31;
    localparam logic [31:0] SP_RESET_VAL = 32'd227;

endpackage

// File: rtl/reg_bank.sv
// MIPS general-purpose register file: 32 x DATA_W, two combinational read ports,
// one synchronous write port. Register 0 is constant zero.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                SP_IDX   = int'(REG_SP),
    parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(SP_RESET_VAL)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [IDX_W-1:0]  ReadReg1,
    input  logic [IDX_W-1:0]  ReadReg2,
    input  logic [IDX_W-1:0]  WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_entry
            if (gi == int'(REG_ZERO)) begin : g_zero
                assign regs[gi] = '0;
            end else begin : g_reg
                localparam logic [DATA_W-1:0] RST_VAL = (gi == SP_IDX) ? SP_RESET : '0;

                logic [DATA_W-1:0] q_reg;
                logic              wr_en;

                // Only the addressed entry sees its enable, so one register changes per edge.
                assign wr_en = RegWrite && (WriteReg == IDX_W'(gi));

                always_ff @(posedge clk) begin
                    if (reset) begin
                        q_reg <= RST_VAL;
                    end else if (wr_en) begin
                        q_reg <= WriteData;
                    end
                end

                assign regs[gi] = q_reg;
            end
        end
    endgenerate

    // No write-through: reads see the pre-edge contents.
    assign ReadData1 = regs[ReadReg1];
    assign ReadData2 = regs[ReadReg2];

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: directed vector table, corner sequences,
// and randomized traffic against an array model of the register file.
module tb_reg_bank;

    localparam int DW = 32;

    logic          clk;
    logic          reset;
    logic          RegWrite;
    logic [4:0]    ReadReg1;
    logic [4:0]    ReadReg2;
    logic [4:0]    WriteReg;
    logic [DW-1:0] WriteData;
    logic [DW-1:0] ReadData1;
    logic [DW-1:0] ReadData2;

    int total;
    int bad;

    logic [DW-1:0] model [32];

    typedef struct {
        logic          rst;
        logic          we;
        logic [4:0]    wr;
        logic [DW-1:0] wd;
        logic [4:0]    r1;
        logic [4:0]    r2;
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
    } vec_t;

    vec_t vecs [11];

    reg_bank dut (
        .clk       (clk),
        .reset     (reset),
        .RegWrite  (RegWrite),
        .ReadReg1  (ReadReg1),
        .ReadReg2  (ReadReg2),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .ReadData1 (ReadData1),
        .ReadData2 (ReadData2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Reference behaviour: reset clears all but $sp, writes to $zero vanish.
    task automatic model_edge(input logic rst, input logic we, input logic [4:0] wr, input logic [DW-1:0] wd);
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = '0;
            model[29] = 32'd227;
        end else if (we && wr != 5'd0) begin
            model[wr] = wd;
        end
    endtask

    task automatic step(input logic rst, input logic we, input logic [4:0] wr, input logic [DW-1:0] wd);
        @(negedge clk);
        reset     = rst;
        RegWrite  = we;
        WriteReg  = wr;
        WriteData = wd;
        @(posedge clk);
        #1;
        model_edge(rst, we, wr, wd);
        reset    = 1'b0;
        RegWrite = 1'b0;
    endtask

    task automatic sweep(input string name);
        for (int i = 0; i < 32; i++) begin
            ReadReg1 = 5'(i);
            ReadReg2 = 5'(31 - i);
            #1;
            check(name, ReadData1, model[i]);
            check(name, ReadData2, model[31 - i]);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b0;
        RegWrite  = 1'b0;
        ReadReg1  = '0;
        ReadReg2  = '0;
        WriteReg  = '0;
        WriteData = '0;
        for (int i = 0; i < 32; i++) model[i] = 'x;

        vecs[0]  = '{1'b0, 1'b1, 5'd8,  32'hDEADBEEF, 5'd8,  5'd8,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[1]  = '{1'b0, 1'b1, 5'd9,  32'hCAFEF00D, 5'd8,  5'd9,  32'hDEADBEEF, 32'hCAFEF00D};
        vecs[2]  = '{1'b0, 1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd8,  32'h00000000, 32'hDEADBEEF};
        vecs[3]  = '{1'b0, 1'b0, 5'd5,  32'h12345678, 5'd5,  5'd29, 32'h00000000, 32'h000000E3};
        vecs[4]  = '{1'b0, 1'b1, 5'd31, 32'h00400010, 5'd31, 5'd31, 32'h00400010, 32'h00400010};
        vecs[5]  = '{1'b0, 1'b1, 5'd29, 32'h00000100, 5'd29, 5'd31, 32'h00000100, 32'h00400010};
        vecs[6]  = '{1'b0, 1'b1, 5'd7,  32'h00000001, 5'd7,  5'd9,  32'h00000001, 32'hCAFEF00D};
        vecs[7]  = '{1'b0, 1'b1, 5'd7,  32'h00000002, 5'd7,  5'd8,  32'h00000002, 32'hDEADBEEF};
        vecs[8]  = '{1'b1, 1'b1, 5'd29, 32'h00000055, 5'd29, 5'd8,  32'h000000E3, 32'h00000000};
        vecs[9]  = '{1'b0, 1'b1, 5'd3,  32'h00000077, 5'd3,  5'd29, 32'h00000077, 32'h000000E3};
        vecs[10] = '{1'b0, 1'b1, 5'd30, 32'hA5A5A5A5, 5'd30, 5'd3,  32'hA5A5A5A5, 32'h00000077};

        // Reset, then every index must show its reset value.
        step(1'b1, 1'b0, 5'd0, '0);
        for (int i = 0; i < 32; i++) begin
            ReadReg1 = 5'(i);
            #1;
            check("reset_sweep", ReadData1, (i == 29) ? 32'd227 : 32'd0);
        end

        for (int v = 0; v < 11; v++) begin
            step(vecs[v].rst, vecs[v].we, vecs[v].wr, vecs[v].wd);
            ReadReg1 = vecs[v].r1;
            ReadReg2 = vecs[v].r2;
            #1;
            check($sformatf("vec%0d_rd1", v), ReadData1, vecs[v].e1);
            check($sformatf("vec%0d_rd2", v), ReadData2, vecs[v].e2);
            if (v == 8) sweep("reset_during_write_sweep");
        end

        // Same-cycle read/write of $ra: old value before the edge, new after.
        step(1'b0, 1'b1, 5'd31, 32'h0000BEEF);
        @(negedge clk);
        RegWrite  = 1'b1;
        WriteReg  = 5'd31;
        WriteData = 32'h00400010;
        ReadReg1  = 5'd31;
        #1;
        check("no_bypass_before_edge", ReadData1, 32'h0000BEEF);
        @(posedge clk);
        #1;
        model_edge(1'b0, 1'b1, 5'd31, 32'h00400010);
        RegWrite = 1'b0;
        check("write_after_edge", ReadData1, 32'h00400010);

        // Toggling write inputs with RegWrite low must not disturb state.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            RegWrite  = 1'b0;
            WriteReg  = (k % 2 == 0) ? 5'bx : 5'd31;
            WriteData = (k % 2 == 0) ? 32'bx : 32'h0BAD0BAD;
            @(posedge clk);
        end
        #1;
        sweep("we_low_sweep");

        // Randomized traffic; reads checked before each edge against the model.
        for (int n = 0; n < 400; n++) begin
            logic          r_rst;
            logic          r_we;
            logic [4:0]    r_wr;
            logic [DW-1:0] r_wd;
            r_rst = ($urandom_range(0, 39) == 0);
            r_we  = 1'($urandom_range(0, 1));
            r_wr  = 5'($urandom_range(0, 31));
            r_wd  = $urandom;
            @(negedge clk);
            reset     = r_rst;
            RegWrite  = r_we;
            WriteReg  = r_wr;
            WriteData = r_wd;
            ReadReg1  = (n % 4 == 0) ? r_wr : 5'($urandom_range(0, 31));
            ReadReg2  = 5'($urandom_range(0, 31));
            #1;
            check("rand_rd1", ReadData1, model[ReadReg1]);
            check("rand_rd2", ReadData2, model[ReadReg2]);
            @(posedge clk);
            #1;
            model_edge(r_rst, r_we, r_wr, r_wd);
        end
        reset    = 1'b0;
        RegWrite = 1'b0;
        #1;
        sweep("final_sweep");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
